// File: rtl/row_mac_engine.sv
// Row dot-product responder: on request, MACs one stored-matrix row against the
// stored vector over N_COLS cycles, writes the sum at the row index, pulses done_row.
module row_mac_engine #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 40,
    parameter int N_COLS = 10,
    parameter int N_ROWS = 10,
    parameter int MAT_AW = 7,
    parameter int VEC_AW = 4
) (
    input  logic                     clk,
    input  logic                     n_reset,
    input  logic                     begin_mult,
    input  logic [3:0]               res_add,
    output logic                     mat_rd_en,
    output logic [MAT_AW-1:0]        mat_addr,
    output logic [VEC_AW-1:0]        vec_addr,
    input  logic signed [DATA_W-1:0] mat_data,
    input  logic signed [DATA_W-1:0] vec_data,
    output logic                     res_wr_en,
    output logic [3:0]               res_wr_addr,
    output logic [ACC_W-1:0]         res_wr_data,
    output logic                     done_row,
    output logic                     row_err,
    output logic                     busy
);

    typedef enum logic [2:0] {IDLE, RUN, DRAIN, WRITE, DONE} state_t;

    localparam logic [MAT_AW-1:0] NC_A     = MAT_AW'(N_COLS);
    localparam logic [VEC_AW-1:0] COL_LAST = VEC_AW'(N_COLS - 1);

    state_t                    state;
    logic [3:0]                row;
    logic [VEC_AW-1:0]         col;
    logic signed [ACC_W-1:0]   acc;
    logic signed [2*DATA_W-1:0] product;
    logic signed [ACC_W-1:0]   product_ext;
    logic signed [ACC_W-1:0]   acc_sum;

    assign product     = mat_data * vec_data;
    assign product_ext = ACC_W'(product);
    assign acc_sum     = acc + product_ext;

    // Read data lags the strobe by one cycle, so the first RUN cycle has nothing
    // to accumulate and DRAIN picks up the product of the last read.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state       <= IDLE;
            row         <= '0;
            col         <= '0;
            acc         <= '0;
            mat_rd_en   <= 1'b0;
            mat_addr    <= '0;
            vec_addr    <= '0;
            res_wr_en   <= 1'b0;
            res_wr_addr <= '0;
            res_wr_data <= '0;
            done_row    <= 1'b0;
            row_err     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (begin_mult) begin
                        busy <= 1'b1;
                        if (32'(res_add) < N_ROWS) begin
                            row       <= res_add;
                            acc       <= '0;
                            col       <= '0;
                            mat_rd_en <= 1'b1;
                            mat_addr  <= MAT_AW'(res_add) * NC_A;
                            vec_addr  <= '0;
                            state     <= RUN;
                        end else begin
                            done_row <= 1'b1;
                            row_err  <= 1'b1;
                            state    <= DONE;
                        end
                    end
                end
                RUN: begin
                    if (col != '0) begin
                        acc <= acc_sum;
                    end
                    if (col == COL_LAST) begin
                        mat_rd_en <= 1'b0;
                        mat_addr  <= '0;
                        vec_addr  <= '0;
                        state     <= DRAIN;
                    end else begin
                        col      <= col + VEC_AW'(1);
                        mat_addr <= mat_addr + MAT_AW'(1);
                        vec_addr <= col + VEC_AW'(1);
                    end
                end
                DRAIN: begin
                    acc         <= acc_sum;
                    res_wr_en   <= 1'b1;
                    res_wr_addr <= row;
                    res_wr_data <= acc_sum;
                    state       <= WRITE;
                end
                WRITE: begin
                    res_wr_en   <= 1'b0;
                    res_wr_addr <= '0;
                    res_wr_data <= '0;
                    done_row    <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    // Inputs are deliberately ignored here: the controller still holds the old request.
                    done_row <= 1'b0;
                    row_err  <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_row_mac_engine.sv
// Scoreboard bench for row_mac_engine: stimulus pushes expected reads, writes and
// done pulses; a negedge monitor pops and compares whatever the DUT presents.
module tb_row_mac_engine;

    logic               clk = 1'b0;
    logic               n_reset;
    logic               begin_mult;
    logic [3:0]         res_add;
    logic               mat_rd_en;
    logic [6:0]         mat_addr;
    logic [3:0]         vec_addr;
    logic signed [15:0] mat_data;
    logic signed [15:0] vec_data;
    logic               res_wr_en;
    logic [3:0]         res_wr_addr;
    logic [39:0]        res_wr_data;
    logic               done_row;
    logic               row_err;
    logic               busy;

    logic               w_begin;
    logic [3:0]         w_res_add;
    logic               w_mat_rd_en;
    logic [6:0]         w_mat_addr;
    logic [3:0]         w_vec_addr;
    logic signed [15:0] w_data = 16'sd32767;
    logic               w_res_wr_en;
    logic [3:0]         w_res_wr_addr;
    logic [31:0]        w_res_wr_data;
    logic               w_done_row;
    logic               w_row_err;
    logic               w_busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int w_writes = 0;

    logic signed [15:0] mat_mem [0:127];
    logic signed [15:0] vec_mem [0:15];

    typedef struct { int maddr; int vaddr; } rd_t;
    typedef struct { int addr; logic [39:0] data; int cyc; } wr_t;
    typedef struct { int cyc; logic err; } done_t;

    rd_t   exp_rd[$];
    wr_t   exp_wr[$];
    done_t exp_done[$];

    int replay_exp [10] = '{285, 330, 375, 420, 465, 510, 555, 600, 645, 690};

    row_mac_engine dut (
        .clk(clk), .n_reset(n_reset), .begin_mult(begin_mult), .res_add(res_add),
        .mat_rd_en(mat_rd_en), .mat_addr(mat_addr), .vec_addr(vec_addr),
        .mat_data(mat_data), .vec_data(vec_data),
        .res_wr_en(res_wr_en), .res_wr_addr(res_wr_addr), .res_wr_data(res_wr_data),
        .done_row(done_row), .row_err(row_err), .busy(busy)
    );

    row_mac_engine #(.ACC_W(32)) dut_wrap (
        .clk(clk), .n_reset(n_reset), .begin_mult(w_begin), .res_add(w_res_add),
        .mat_rd_en(w_mat_rd_en), .mat_addr(w_mat_addr), .vec_addr(w_vec_addr),
        .mat_data(w_data), .vec_data(w_data),
        .res_wr_en(w_res_wr_en), .res_wr_addr(w_res_wr_addr), .res_wr_data(w_res_wr_data),
        .done_row(w_done_row), .row_err(w_row_err), .busy(w_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Operand storage model: one-cycle read latency
    always @(posedge clk) begin
        if (mat_rd_en) begin
            mat_data <= mat_mem[mat_addr];
            vec_data <= vec_mem[vec_addr];
        end
    end

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic report_fail(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: event not expected/seen (cycle %0d)", name, cyc);
    endtask

    // Called at a negedge while the DUT is in IDLE; t0 is this cycle
    task automatic apply_stimulus(input logic [3:0] row, input logic [39:0] exp_data);
        int t0;
        t0 = cyc;
        begin_mult = 1'b1;
        res_add = row;
        if (row < 4'd10) begin
            for (int c = 0; c < 10; c++) exp_rd.push_back('{int'(row) * 10 + c, c});
            exp_wr.push_back('{int'(row), exp_data, t0 + 12});
            exp_done.push_back('{t0 + 13, 1'b0});
        end else begin
            exp_done.push_back('{t0 + 1, 1'b1});
        end
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!done_row && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!done_row) report_fail({name, "_timeout"});
    endtask

    always @(negedge clk) begin
        if (n_reset) begin
            if (mat_rd_en) begin
                if (exp_rd.size() == 0) report_fail("unexpected_read");
                else begin
                    rd_t r;
                    r = exp_rd.pop_front();
                    check_output("rd_mat_addr", 64'(mat_addr), 64'(r.maddr));
                    check_output("rd_vec_addr", 64'(vec_addr), 64'(r.vaddr));
                end
            end
            if (res_wr_en) begin
                if (exp_wr.size() == 0) report_fail("unexpected_write");
                else begin
                    wr_t w;
                    w = exp_wr.pop_front();
                    check_output("wr_addr", 64'(res_wr_addr), 64'(w.addr));
                    check_output("wr_data", 64'(res_wr_data), 64'(w.data));
                    check_output("wr_cycle", 64'(cyc), 64'(w.cyc));
                end
            end
            if (done_row) begin
                if (exp_done.size() == 0) report_fail("unexpected_done");
                else begin
                    done_t d;
                    d = exp_done.pop_front();
                    check_output("done_cycle", 64'(cyc), 64'(d.cyc));
                    check_output("row_err", 64'(row_err), 64'(d.err));
                end
            end
            if (w_res_wr_en) begin
                check_output("wrap_data", 64'(w_res_wr_data), 64'h7FF6000A);
                w_writes++;
            end
        end
    end

    task automatic load_ramp(input int vec_mode);
        for (int r = 0; r < 10; r++)
            for (int c = 0; c < 10; c++) mat_mem[r*10 + c] = 16'(r + c);
        for (int c = 0; c < 16; c++) vec_mem[c] = (vec_mode == 0) ? 16'sd1 : 16'(c);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        int n;
        for (int i = 0; i < 128; i++) mat_mem[i] = '0;
        for (int i = 0; i < 16; i++) vec_mem[i] = '0;
        mat_data = '0;
        vec_data = '0;
        n_reset = 1'b0;
        begin_mult = 1'b0;
        res_add = '0;
        w_begin = 1'b0;
        w_res_add = '0;
        repeat (3) @(negedge clk);
        n_reset = 1'b1;
        repeat (2) @(negedge clk);
        check_output("rst_mat_rd_en", 64'(mat_rd_en), 0);
        check_output("rst_mat_addr", 64'(mat_addr), 0);
        check_output("rst_vec_addr", 64'(vec_addr), 0);
        check_output("rst_res_wr_en", 64'(res_wr_en), 0);
        check_output("rst_res_wr_addr", 64'(res_wr_addr), 0);
        check_output("rst_res_wr_data", 64'(res_wr_data), 0);
        check_output("rst_done_row", 64'(done_row), 0);
        check_output("rst_row_err", 64'(row_err), 0);
        check_output("rst_busy", 64'(busy), 0);

        $display("[TB] ramp row 3, vector of ones");
        load_ramp(0);
        @(negedge clk);
        apply_stimulus(4'd3, 40'd75);
        wait_done("row3");
        begin_mult = 1'b0;

        $display("[TB] signed row 0");
        for (int c = 0; c < 10; c++) begin
            mat_mem[c] = -16'sd1;
            vec_mem[c] = 16'sd2;
        end
        @(negedge clk);
        apply_stimulus(4'd0, 40'hFF_FFFF_FFEC);
        wait_done("signed");
        begin_mult = 1'b0;

        $display("[TB] controller replay, begin_mult held");
        load_ramp(1);
        @(negedge clk);
        for (int r = 0; r < 10; r++) begin
            apply_stimulus(4'(r), 40'(replay_exp[r]));
            wait_done("replay");
            if (r == 9) begin_mult = 1'b0;
            @(negedge clk);
        end

        $display("[TB] out-of-range row");
        apply_stimulus(4'd12, 40'd0);
        wait_done("invalid");
        begin_mult = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] reset mid-row");
        apply_stimulus(4'd2, 40'd0);
        repeat (5) @(negedge clk);
        check_output("midrun_busy", 64'(busy), 1);
        check_output("midrun_rd_en", 64'(mat_rd_en), 1);
        @(posedge clk);
        #2;
        n_reset = 1'b0;
        begin_mult = 1'b0;
        exp_rd.delete();
        exp_wr.delete();
        exp_done.delete();
        #1;
        check_output("abort_rd_en", 64'(mat_rd_en), 0);
        check_output("abort_mat_addr", 64'(mat_addr), 0);
        check_output("abort_busy", 64'(busy), 0);
        check_output("abort_res_wr_en", 64'(res_wr_en), 0);
        check_output("abort_done_row", 64'(done_row), 0);
        repeat (2) @(negedge clk);
        n_reset = 1'b1;
        repeat (20) @(negedge clk);

        $display("[TB] accumulator wrap, ACC_W=32");
        w_begin = 1'b1;
        w_res_add = 4'd0;
        n = 0;
        @(negedge clk);
        while (!w_done_row && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!w_done_row) report_fail("wrap_timeout");
        w_begin = 1'b0;
        repeat (3) @(negedge clk);

        check_output("wrap_write_count", 64'(w_writes), 1);
        check_output("pending_reads", 64'(exp_rd.size()), 0);
        check_output("pending_writes", 64'(exp_wr.size()), 0);
        check_output("pending_dones", 64'(exp_done.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
